// File: rtl/robo_pkg.sv
// Shared types and constants for the left-hand wall-following robot controller.
// Heading codes describe the grid map and are used by map models around the controller.
package robo_pkg;

  typedef enum logic [2:0] {
    SEARCH  = 3'd0,
    FOLLOW  = 3'd1,
    AFTER_L = 3'd2,
    TURN_R  = 3'd3,
    REMOVE  = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_AVANCAR  = 2'd1,
    CMD_GIRAR    = 2'd2,
    CMD_RECOLHER = 2'd3
  } cmd_t;

  localparam logic [1:0] HEAD_N = 2'd0;
  localparam logic [1:0] HEAD_S = 2'd1;
  localparam logic [1:0] HEAD_L = 2'd2;
  localparam logic [1:0] HEAD_O = 2'd3;

  // Heading after one counter-clockwise quarter turn: N -> O -> S -> L -> N.
  function automatic logic [1:0] heading_after_left(input logic [1:0] h);
    logic [1:0] r;
    case (h)
      HEAD_N:  r = HEAD_O;
      HEAD_O:  r = HEAD_S;
      HEAD_S:  r = HEAD_L;
      HEAD_L:  r = HEAD_N;
      default: r = HEAD_N;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/robo.sv
// Left-hand wall-following controller: one registered command per cycle
// (advance, rotate left, or remove debris), chosen from four cell sensors.
module robo
  import robo_pkg::*;
#(
  parameter int TURN_CNT_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic avancar,
  output logic girar,
  output logic recolher_entulho
);

  // A right turn is one left turn now plus this many more from TURN_R.
  localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(2'd2);
  localparam logic [TURN_CNT_W-1:0] TURN_ONE  = TURN_CNT_W'(1'b1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [TURN_CNT_W-1:0] cnt_r;
  logic [TURN_CNT_W-1:0] cnt_nxt_s;
  logic                  left_start_r;
  logic                  left_start_nxt_s;
  logic                  wall_r;
  logic                  wall_nxt_s;
  cmd_t                  cmd_s;

  // Next-state and command selection in global priority order.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    cmd_s            = CMD_NONE;
    left_start_nxt_s = left_start_r | ~under;

    if (state_r == DONE) begin
      state_nxt_s = DONE;
    end else if (under && left_start_r) begin
      state_nxt_s = DONE;
    end else if (barrier) begin
      state_nxt_s = REMOVE;
      cmd_s       = CMD_RECOLHER;
    end else begin
      case (state_r)
        SEARCH: begin
          if (head) begin
            cmd_s       = CMD_GIRAR;
            cnt_nxt_s   = TURN_LOAD;
            state_nxt_s = TURN_R;
          end else if (left) begin
            cmd_s       = CMD_AVANCAR;
            state_nxt_s = FOLLOW;
          end else begin
            cmd_s       = CMD_AVANCAR;
          end
        end
        FOLLOW: begin
          if (!left) begin
            cmd_s       = CMD_GIRAR;
            state_nxt_s = AFTER_L;
          end else if (!head) begin
            cmd_s       = CMD_AVANCAR;
          end else begin
            cmd_s       = CMD_GIRAR;
            cnt_nxt_s   = TURN_LOAD;
            state_nxt_s = TURN_R;
          end
        end
        AFTER_L: begin
          if (!head) begin
            cmd_s       = CMD_AVANCAR;
            state_nxt_s = FOLLOW;
          end else begin
            cmd_s       = CMD_GIRAR;
            cnt_nxt_s   = TURN_LOAD;
            state_nxt_s = TURN_R;
          end
        end
        TURN_R: begin
          cmd_s = CMD_GIRAR;
          // A corrupted zero count also exits rather than wrapping.
          if (cnt_r <= TURN_ONE) begin
            cnt_nxt_s   = '0;
            state_nxt_s = FOLLOW;
          end else begin
            cnt_nxt_s   = cnt_r - TURN_ONE;
          end
        end
        REMOVE: begin
          if (wall_r) begin
            state_nxt_s = FOLLOW;
          end else begin
            state_nxt_s = SEARCH;
          end
        end
        default: begin
          state_nxt_s = SEARCH;
          cnt_nxt_s   = '0;
        end
      endcase
    end

    wall_nxt_s = wall_r | (state_nxt_s inside {FOLLOW, AFTER_L, TURN_R});
  end

  // State, flags and registered one-hot command outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= SEARCH;
      cnt_r            <= '0;
      left_start_r     <= 1'b0;
      wall_r           <= 1'b0;
      avancar          <= 1'b0;
      girar            <= 1'b0;
      recolher_entulho <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      cnt_r            <= cnt_nxt_s;
      left_start_r     <= left_start_nxt_s;
      wall_r           <= wall_nxt_s;
      avancar          <= (cmd_s == CMD_AVANCAR);
      girar            <= (cmd_s == CMD_GIRAR);
      recolher_entulho <= (cmd_s == CMD_RECOLHER);
    end
  end

endmodule

// File: tb/tb_robo.sv
// Directed scoreboard bench for robo: expected commands are queued as each
// stimulus step is driven and compared one edge later; heading tracked on a map model.
module tb_robo;
  import robo_pkg::*;

  logic clock = 1'b0;
  logic reset, head, left, under, barrier;
  logic avancar, girar, recolher_entulho;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [1:0] heading;
  logic [1:0] start_heading;

  localparam logic [2:0] E_NO = 3'b000;
  localparam logic [2:0] E_AV = 3'b100;
  localparam logic [2:0] E_GI = 3'b010;
  localparam logic [2:0] E_RE = 3'b001;

  robo #(.TURN_CNT_W(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .head             (head),
    .left             (left),
    .under            (under),
    .barrier          (barrier),
    .avancar          (avancar),
    .girar            (girar),
    .recolher_entulho (recolher_entulho)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] rot_left(input logic [1:0] h);
    logic [1:0] r;
    case (h)
      HEAD_N:  r = HEAD_O;
      HEAD_O:  r = HEAD_S;
      HEAD_S:  r = HEAD_L;
      default: r = HEAD_N;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] h);
    logic [1:0] r;
    case (h)
      HEAD_N:  r = HEAD_S;
      HEAD_S:  r = HEAD_N;
      HEAD_L:  r = HEAD_O;
      default: r = HEAD_L;
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs, queue the expected command, compare after the edge.
  task automatic step(input logic r, input logic h, input logic l, input logic u,
                      input logic b, input logic [2:0] e, input string tag);
    logic [2:0] obs;
    logic [2:0] want;
    reset   = r;
    head    = h;
    left    = l;
    under   = u;
    barrier = b;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    obs  = {avancar, girar, recolher_entulho};
    want = exp_q.pop_front();
    checks++;
    assert ($onehot0(obs)) else begin
      errors++;
      $error("FAIL onehot_%s: observed %b required at most one bit set", tag, obs);
    end
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed {av,gi,re}=%b expected %b", tag, obs, want);
    end
    if (girar === 1'b1) heading = rot_left(heading);
  endtask

  task automatic check_heading(input logic [1:0] want, input string tag);
    checks++;
    assert (heading === want) else begin
      errors++;
      $error("FAIL %s: observed heading %0d expected %0d", tag, heading, want);
    end
  endtask

  initial begin
    heading = HEAD_N;

    // Reset with the robot on the black start cell.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_NO, "reset0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_NO, "reset1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_AV, "first_cmd");

    // SEARCH hits a wall ahead: right turn as three left turns.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_GI, "search_turn0");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_GI, "search_turn1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_GI, "search_turn2");
    check_heading(HEAD_L, "heading_east");

    // FOLLOW straight along the left wall, robot now off the start cell.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_AV, "follow_fwd");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_GI, "left_opening");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_AV, "after_l_fwd");
    check_heading(HEAD_N, "heading_after_left");

    // Medium debris: six removal cycles, one idle edge, then resume in FOLLOW.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_RE, "debris");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_NO, "debris_idle");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_AV, "debris_resume");

    // Dead end: two right turns, sensors ignored while turning.
    start_heading = heading;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_GI, "dead_a0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_GI, "dead_a1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_GI, "dead_a2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_GI, "dead_b0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_GI, "dead_b1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_GI, "dead_b2");
    check_heading(opposite(start_heading), "dead_end_reversed");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_AV, "dead_exit");

    // Pipe end: outputs stay 0 whatever the sensors say.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_NO, "pipe_end");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NO, "done_barrier");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_NO, "done_head");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NO, "done_open");

    // Reset restarts in SEARCH; debris with no wall returns to SEARCH.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_NO, "restart_reset");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_AV, "restart_search");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RE, "search_debris");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_NO, "search_debris_idle");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_AV, "search_after_debris");

    // Reset mid-removal and mid-turn leaves nothing behind.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RE, "abort_remove0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_NO, "abort_remove_rst");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_AV, "abort_remove_after");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_GI, "abort_turn0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_NO, "abort_turn_rst");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_AV, "abort_turn_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
